// File: rtl/game_sequencer.sv
// game_sequencer: Mastermind controller that latches the secret code, scores guesses serially, logs history and declares win or loss
module game_sequencer #(
  parameter int MAX_TURNS = 8,
  parameter int COLOR_W   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode,
  input  logic                 select,
  input  logic [COLOR_W-1:0]   code0,
  input  logic [COLOR_W-1:0]   code1,
  input  logic [COLOR_W-1:0]   code2,
  input  logic [COLOR_W-1:0]   code3,
  input  logic [COLOR_W-1:0]   guess0,
  input  logic [COLOR_W-1:0]   guess1,
  input  logic [COLOR_W-1:0]   guess2,
  input  logic [COLOR_W-1:0]   guess3,
  output logic [1:0]           feedback0,
  output logic [1:0]           feedback1,
  output logic [1:0]           feedback2,
  output logic [1:0]           feedback3,
  output logic [3:0]           turn,
  output logic                 hist_we,
  output logic [4*COLOR_W-1:0] hist_data,
  output logic                 new_game,
  output logic                 busy,
  output logic                 game_over,
  output logic                 win
);
  typedef enum logic [2:0] {IDLE, PLAY, EXACT, PARTIAL, RESULT, WIN, LOSE} state_t;
  state_t state, state_nxt;
  logic select_q, sel_ok, hit, scoring;
  logic [COLOR_W-1:0] code_r [4];
  logic [COLOR_W-1:0] guess_r [4];
  logic [3:0] used_c, used_g, idx;
  logic [2:0] exact, partial, partial_nxt;
  logic [1:0] fb [4];
  logic [1:0] gi, cj;
  assign sel_ok = select & ~select_q & ~mode & (state == IDLE || state == PLAY || state == WIN || state == LOSE);
  assign scoring = state == EXACT || state == PARTIAL;
  assign gi = state == EXACT ? idx[1:0] : idx[3:2];
  assign cj = idx[1:0];
  assign hit = scoring & ~used_g[gi] & ~used_c[cj] & (guess_r[gi] == code_r[cj]);
  assign partial_nxt = partial + 3'(state == PARTIAL && hit);
  assign busy = scoring || state == RESULT;
  assign game_over = state == WIN || state == LOSE;
  assign win = state == WIN;
  assign hist_we = state == RESULT;
  assign hist_data = {guess_r[3], guess_r[2], guess_r[1], guess_r[0]};
  assign feedback0 = fb[0];
  assign feedback1 = fb[1];
  assign feedback2 = fb[2];
  assign feedback3 = fb[3];
  always_ff @(posedge clk) state <= !reset ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = sel_ok ? PLAY : IDLE;
      PLAY:    state_nxt = sel_ok ? EXACT : PLAY;
      EXACT:   state_nxt = idx[1:0] == 2'd3 ? PARTIAL : EXACT;
      PARTIAL: state_nxt = idx == 4'd15 ? RESULT : PARTIAL;
      RESULT:  state_nxt = exact == 3'd4 ? WIN : turn == 4'(MAX_TURNS) ? LOSE : PLAY;
      WIN:     state_nxt = sel_ok ? IDLE : WIN;
      LOSE:    state_nxt = sel_ok ? IDLE : LOSE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      select_q <= 1'b0;
      new_game <= 1'b0;
      code_r   <= '{default: '0};
      guess_r  <= '{default: '0};
      fb       <= '{default: '0};
      used_c   <= '0;
      used_g   <= '0;
      idx      <= '0;
      exact    <= '0;
      partial  <= '0;
      turn     <= '0;
    end else begin
      select_q <= select;
      new_game <= state == IDLE && sel_ok;
      if (state == IDLE && sel_ok) begin
        code_r <= '{code0, code1, code2, code3};
        turn   <= '0;
        fb     <= '{default: '0};
      end
      if (game_over && sel_ok)
        fb <= '{default: '0};
      if (state == PLAY && sel_ok) begin
        guess_r <= '{guess0, guess1, guess2, guess3};
        used_c  <= '0;
        used_g  <= '0;
        exact   <= '0;
        partial <= '0;
        idx     <= '0;
      end
      if (scoring) begin
        idx     <= state == EXACT && idx[1:0] == 2'd3 ? 4'd0 : idx + 4'd1;
        exact   <= exact + 3'(state == EXACT && hit);
        partial <= partial_nxt;
        if (hit) begin
          used_g[gi] <= 1'b1;
          used_c[cj] <= 1'b1;
        end
      end
      if (state == PARTIAL && idx == 4'd15) begin
        for (int k = 0; k < 4; k++)
          fb[k] <= 3'(k) < exact ? 2'd2 : 3'(k) < exact + partial_nxt ? 2'd1 : 2'd0;
        turn <= turn == 4'd15 ? 4'd15 : turn + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: table-driven and randomized self-checking bench for game_sequencer
module tb_game_sequencer;
  logic clk = 0, reset = 0, mode = 0, select = 0;
  logic [11:0] code_w = '0, guess_w = '0, hist_data;
  logic [1:0] f0, f1, f2, f3;
  logic [7:0] fb_w;
  logic [3:0] turn;
  logic hist_we, new_game, busy, game_over, win;
  int tests = 0, fails = 0;
  typedef struct { logic [11:0] c; logic [11:0] g; logic [7:0] f; } vec_t;
  vec_t vt [3];
  always #5 clk = ~clk;
  assign fb_w = {f3, f2, f1, f0};
  game_sequencer #(.MAX_TURNS(8), .COLOR_W(3)) dut (
    .clk(clk), .reset(reset), .mode(mode), .select(select),
    .code0(code_w[2:0]), .code1(code_w[5:3]), .code2(code_w[8:6]), .code3(code_w[11:9]),
    .guess0(guess_w[2:0]), .guess1(guess_w[5:3]), .guess2(guess_w[8:6]), .guess3(guess_w[11:9]),
    .feedback0(f0), .feedback1(f1), .feedback2(f2), .feedback3(f3),
    .turn(turn), .hist_we(hist_we), .hist_data(hist_data), .new_game(new_game),
    .busy(busy), .game_over(game_over), .win(win)
  );
  function automatic logic [11:0] pk(int a, int b, int c, int d);
    return {d[2:0], c[2:0], b[2:0], a[2:0]};
  endfunction
  function automatic logic [7:0] model(logic [11:0] c, logic [11:0] g);
    int ex = 0, cm = 0;
    int cc [8], cg [8];
    logic [7:0] f;
    for (int i = 0; i < 8; i++) begin
      cc[i] = 0;
      cg[i] = 0;
    end
    for (int k = 0; k < 4; k++) begin
      ex += int'(c[3*k+:3] == g[3*k+:3]);
      cc[c[3*k+:3]]++;
      cg[g[3*k+:3]]++;
    end
    for (int i = 0; i < 8; i++) cm += cc[i] < cg[i] ? cc[i] : cg[i];
    for (int k = 0; k < 4; k++) f[2*k+:2] = k < ex ? 2'd2 : k < cm ? 2'd1 : 2'd0;
    return f;
  endfunction
  task automatic chk(string n, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic press;
    select = 1;
    @(posedge clk); #1 select = 0;
  endtask
  task automatic do_reset;
    reset = 0;
    @(posedge clk); #1 reset = 1;
  endtask
  task automatic start_game(input logic [11:0] c);
    code_w = c;
    press;
    chk("new_game_pulse", new_game, 1);
    chk("start_turn", turn, 0);
    chk("start_fb", fb_w, 0);
    chk("start_over", game_over, 0);
    @(posedge clk); #1;
    chk("new_game_end", new_game, 0);
  endtask
  task automatic submit(input logic [11:0] g, input logic [7:0] efb, input int et, input bit ew, input bit eo, input bit inj);
    int hw = 0;
    guess_w = g;
    press;
    for (int k = 1; k <= 21; k++) begin
      if (inj && k == 10) select = 1;
      if (inj && k == 11) select = 0;
      @(posedge clk); #1;
      hw += int'(hist_we);
      if (k == 20) begin
        chk("hist_we_at_20", hist_we, 1);
        chk("busy_result", busy, 1);
        chk("feedback", fb_w, efb);
        chk("turn", turn, et);
        chk("hist_data", hist_data, g);
      end
    end
    chk("hist_we_count", hw, 1);
    chk("busy_after", busy, 0);
    chk("win", win, ew);
    chk("game_over", game_over, eo);
  endtask
  initial begin
    int hw, bz, tm;
    bit w, over;
    logic [11:0] c, g;
    logic [7:0] f;
    vt[0] = '{pk(1,2,3,4), pk(1,2,3,4), 8'hAA};
    vt[1] = '{pk(1,2,3,4), pk(4,3,2,1), 8'h55};
    vt[2] = '{pk(1,1,2,2), pk(1,2,1,1), 8'h16};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_turn", turn, 0);
    chk("rst_fb", fb_w, 0);
    chk("rst_hist_we", hist_we, 0);
    chk("rst_new_game", new_game, 0);
    chk("rst_win", win, 0);
    chk("rst_busy", busy, 0);
    chk("rst_over", game_over, 0);
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      do_reset;
      start_game(vt[i].c);
      submit(vt[i].g, vt[i].f, 1, vt[i].f == 8'hAA, vt[i].f == 8'hAA, 0);
    end
    do_reset;
    start_game(pk(1,2,3,4));
    for (int t = 1; t <= 8; t++) submit(pk(5,5,5,5), 8'h00, t, 0, t == 8, 0);
    press;
    hw = 0;
    repeat (3) begin
      @(posedge clk); #1;
      hw += int'(hist_we);
    end
    chk("lose_exit_hist_we", hw, 0);
    chk("lose_exit_over", game_over, 0);
    chk("lose_exit_busy", busy, 0);
    chk("lose_exit_turn", turn, 8);
    do_reset;
    start_game(pk(1,2,3,4));
    guess_w = pk(4,3,2,1);
    select = 1;
    hw = 0;
    repeat (100) begin
      @(posedge clk); #1;
      hw += int'(hist_we);
    end
    select = 0;
    @(posedge clk); #1;
    chk("held_hist_we", hw, 1);
    chk("held_turn", turn, 1);
    chk("held_fb", fb_w, 8'h55);
    mode = 1;
    press;
    hw = 0;
    bz = 0;
    repeat (4) begin
      @(posedge clk); #1;
      hw += int'(hist_we);
      bz += int'(busy);
    end
    mode = 0;
    chk("mode_busy", bz, 0);
    chk("mode_hist_we", hw, 0);
    submit(pk(1,2,3,4), 8'hAA, 2, 1, 1, 1);
    do_reset;
    start_game(pk(1,2,3,4));
    submit(pk(4,3,2,1), 8'h55, 1, 0, 0, 0);
    guess_w = pk(1,2,3,4);
    press;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    reset = 0;
    @(posedge clk); #1 reset = 1;
    chk("mid_rst_turn", turn, 0);
    chk("mid_rst_fb", fb_w, 0);
    chk("mid_rst_busy", busy, 0);
    hw = 0;
    repeat (12) begin
      @(posedge clk); #1;
      hw += int'(hist_we);
    end
    chk("mid_rst_hist_we", hw, 0);
    chk("mid_rst_over", game_over, 0);
    do_reset;
    for (int n = 0; n < 15; n++) begin
      c = 12'($urandom);
      start_game(c);
      tm = 0;
      over = 0;
      while (!over) begin
        g = $urandom_range(0, 3) == 0 ? c : 12'($urandom);
        f = model(c, g);
        tm++;
        w = f == 8'hAA;
        over = w || tm == 8;
        submit(g, f, tm, w, over, 0);
      end
      press;
      chk("restart_over", game_over, 0);
      chk("restart_win", win, 0);
      chk("restart_fb", fb_w, 0);
      chk("restart_turn", turn, tm);
      @(posedge clk); #1;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
